// File: rtl/xbar_ingress_fifo.sv
// Packet-aware ingress FIFO in front of the crossbar: frame-boundary admission
// control on the input, first-word-fall-through AXI-stream output.
module xbar_ingress_fifo #(
  parameter int unsigned DEPTH           = 512,
  parameter int unsigned MAX_FRAME_WORDS = 192
) (
  input  logic        clk_fabric,
  input  logic        rst,
  input  logic        rx_tvalid,
  output logic        rx_tready,
  input  logic [63:0] rx_tdata,
  input  logic [7:0]  rx_tkeep,
  input  logic        rx_tlast,
  input  logic [6:0]  rx_tdest,
  input  logic [11:0] rx_tuser,
  output logic        tx_tvalid,
  input  logic        tx_tready,
  output logic [63:0] tx_tdata,
  output logic [7:0]  tx_tkeep,
  output logic        tx_tlast,
  output logic [6:0]  tx_tdest,
  output logic [11:0] tx_tuser,
  output logic [15:0] oversize_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned OW = AW + 1;
  localparam int unsigned BW = $clog2(MAX_FRAME_WORDS + 1);

  typedef struct packed {
    logic [11:0] tuser;
    logic [6:0]  tdest;
    logic        tlast;
    logic [7:0]  tkeep;
    logic [63:0] tdata;
  } beat_t;

  typedef enum logic [1:0] {IDLE, INPKT, DROP} in_state_e;

  in_state_e     state;
  logic          rdy_q;
  logic [BW-1:0] beat_cnt;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [OW-1:0] occ;
  logic [OW-1:0] ram_cnt;
  logic          s1_valid;
  beat_t         mem [DEPTH];
  beat_t         ram_q;
  beat_t         out_q;

  logic          rx_acc;
  logic          wr_en;
  logic          rd_en;
  logic          tx_hs;
  logic          out_ready;
  logic          trunc;
  logic          busy_next;
  logic [BW-1:0] beat_num;
  logic [OW-1:0] occ_next;
  beat_t         wr_beat;

  // Ready is forced low while reset is held and comes up with the first free cycle.
  assign rx_tready = rdy_q & ~rst;

  assign tx_tdata = out_q.tdata;
  assign tx_tkeep = out_q.tkeep;
  assign tx_tlast = out_q.tlast;
  assign tx_tdest = out_q.tdest;
  assign tx_tuser = out_q.tuser;

  always_comb begin
    rx_acc    = rx_tvalid && rx_tready;
    beat_num  = (state == INPKT) ? beat_cnt + BW'(1) : BW'(1);
    trunc     = rx_acc && (state != DROP) && !rx_tlast && (beat_num == BW'(MAX_FRAME_WORDS));
    wr_en     = rx_acc && (state != DROP);
    wr_beat.tuser = rx_tuser;
    wr_beat.tdest = rx_tdest;
    wr_beat.tlast = rx_tlast | trunc;
    wr_beat.tkeep = rx_tkeep;
    wr_beat.tdata = rx_tdata;
    tx_hs     = tx_tvalid && tx_tready;
    out_ready = !tx_tvalid || tx_tready;
    rd_en     = (ram_cnt != '0) && (!s1_valid || out_ready);
    // Occupancy covers RAM plus both output stages, so it drops only on a tx handshake.
    occ_next  = occ + OW'(wr_en) - OW'(tx_hs);
    busy_next = (state == IDLE) ? (rx_acc && !rx_tlast) : !(rx_acc && rx_tlast);
  end

  // Storage with registered read port.
  always_ff @(posedge clk_fabric) begin
    if (wr_en) mem[wr_ptr] <= wr_beat;
    if (rd_en) ram_q <= mem[rd_ptr];
  end

  // Output payload register only advances when the consumer can take a new beat.
  always_ff @(posedge clk_fabric) begin
    if (out_ready && s1_valid) out_q <= ram_q;
  end

  always_ff @(posedge clk_fabric) begin
    if (rst) begin
      state          <= IDLE;
      rdy_q          <= 1'b1;
      beat_cnt       <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      occ            <= '0;
      ram_cnt        <= '0;
      s1_valid       <= 1'b0;
      tx_tvalid      <= 1'b0;
      oversize_count <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      occ     <= occ_next;
      ram_cnt <= ram_cnt + OW'(wr_en) - OW'(rd_en);

      if (rd_en)                      s1_valid <= 1'b1;
      else if (s1_valid && out_ready) s1_valid <= 1'b0;
      if (out_ready)                  tx_tvalid <= s1_valid;

      case (state)
        IDLE, INPKT: begin
          if (rx_acc) begin
            beat_cnt <= beat_num;
            if (rx_tlast) begin
              state <= IDLE;
            end else if (trunc) begin
              state <= DROP;
              if (oversize_count != '1) oversize_count <= oversize_count + 16'd1;
            end else begin
              state <= INPKT;
            end
          end
        end
        DROP:    if (rx_acc && rx_tlast) state <= IDLE;
        default: state <= IDLE;
      endcase

      // Mid-frame the input must never stall; at a boundary admit only a full max frame.
      rdy_q <= busy_next || (occ_next <= OW'(DEPTH - MAX_FRAME_WORDS));
    end
  end

endmodule
